bcd_to_7seg_mux: RTL and testbench

- Registered BCD-to-seven-segment decoder for one display digit.
- Converts a 4-bit BCD code to a 7-bit segment pattern through a combinational 16:1 pattern multiplexer, then registers the result.
- Sits between counter/arithmetic logic and the display pin drivers.
- Non-BCD codes (10-15) are blanked and flagged, unless hex decode is compiled in.

---
 rtl/bcd7seg_pkg.sv | 34 +++
 rtl/bcd7seg_decode.sv | 28 ++
 rtl/bcd_to_7seg_mux.sv | 45 ++++
 tb/tb_bcd_to_7seg_mux.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bcd7seg_pkg.sv
// Shared types and glyph patterns for the BCD-to-seven-segment decoder.
// Patterns are active-high, bit6..bit0 = a,b,c,d,e,f,g.
package bcd7seg_pkg;

  typedef logic [6:0] seg_t;

  // Bit positions within seg_t
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h7B;
  localparam seg_t SEG_HEX_A = 7'h77;
  localparam seg_t SEG_HEX_B = 7'h1F;
  localparam seg_t SEG_HEX_C = 7'h4E;
  localparam seg_t SEG_HEX_D = 7'h3D;
  localparam seg_t SEG_HEX_E = 7'h4F;
  localparam seg_t SEG_HEX_F = 7'h47;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd7seg_decode.sv
// Combinational 16:1 glyph mux from a 4-bit code to an active-high segment pattern.
// Define BCD7SEG_HEX_EN to show hex glyphs for codes 10-15 instead of blanking them.
module bcd7seg_decode
  import bcd7seg_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg,
  output logic       invalid
);

  // Index 15 is the leftmost element. An indexed table keeps X on code visible.
`ifdef BCD7SEG_HEX_EN
  localparam seg_t [15:0] GLYPH = {SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
                                   SEG_HEX_B, SEG_HEX_A, SEG_9, SEG_8,
                                   SEG_7, SEG_6, SEG_5, SEG_4,
                                   SEG_3, SEG_2, SEG_1, SEG_0};
  assign invalid = 1'b0;
`else
  localparam seg_t [15:0] GLYPH = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
                                   SEG_BLANK, SEG_BLANK, SEG_9, SEG_8,
                                   SEG_7, SEG_6, SEG_5, SEG_4,
                                   SEG_3, SEG_2, SEG_1, SEG_0};
  assign invalid = (code > 4'd9);
`endif

  assign seg = GLYPH[code];

endmodule

// File: rtl/bcd_to_7seg_mux.sv
// Registered BCD-to-seven-segment decoder for one digit, with optional output inversion.
// Build option: BCD7SEG_HEX_EN (hex glyphs for codes 10-15, invalid flag held 0).
module bcd_to_7seg_mux
  import bcd7seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_in,
  output logic [6:0] seven_seg_out,
  output logic       invalid_out
);

  // Inverting the blank pattern too keeps "all segments off" in reset for either polarity.
  localparam seg_t SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  seg_t seg_raw;
  seg_t seg_d;
  seg_t seg_q;
  logic invalid_d;
  logic invalid_q;

  bcd7seg_decode u_decode (
    .code    (bcd_in),
    .seg     (seg_raw),
    .invalid (invalid_d)
  );

  assign seg_d = ACTIVE_LOW ? ~seg_raw : seg_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q     <= SEG_OFF;
      invalid_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      invalid_q <= invalid_d;
    end
  end

  assign seven_seg_out = seg_q;
  assign invalid_out   = invalid_q;

endmodule

// File: tb/tb_bcd_to_7seg_mux.sv
// Randomized self-checking bench for bcd_to_7seg_mux against a table-driven reference.
// Honours BCD7SEG_HEX_EN and the ACTIVE_LOW parameter.
module tb_bcd_to_7seg_mux;

  parameter bit ACTIVE_LOW = 1'b0;

  logic       clk;
  logic       rst;
  logic [3:0] bcd_in;
  logic [6:0] seven_seg_out;
  logic       invalid_out;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_to_7seg_mux #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bcd_in        (bcd_in),
    .seven_seg_out (seven_seg_out),
    .invalid_out   (invalid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] dec_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [6:0] hex_tab [6]  = '{7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference: {invalid, segments} for a code, with polarity applied to segments only.
  function automatic logic [7:0] model(input int code);
    logic [6:0] pat;
    logic       inv;
    if (code < 10) begin
      pat = dec_tab[code];
      inv = 1'b0;
    end else begin
`ifdef BCD7SEG_HEX_EN
      pat = hex_tab[code - 10];
      inv = 1'b0;
`else
      pat = 7'h00;
      inv = 1'b1;
`endif
    end
    if (ACTIVE_LOW) pat = ~pat;
    return {inv, pat};
  endfunction

  function automatic logic [7:0] reset_val();
    return {1'b0, (ACTIVE_LOW ? 7'h7F : 7'h00)};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got inv=%b seg=%h, expected inv=%b seg=%h",
               tag, got[7], got[6:0], exp[7], exp[6:0]);
    end
  endtask

  // Present a code, clock it in, and check the output 1 time unit after the edge.
  task automatic step(input int code, input string tag);
    bcd_in = 4'(code);
    @(posedge clk);
    #1;
    check_eq(tag, {invalid_out, seven_seg_out}, model(code));
  endtask

  initial begin
    rst    = 1'b1;
    bcd_in = 4'(8);
    #2;
    check_eq("reset_no_clk", {invalid_out, seven_seg_out}, reset_val());

    // Reset dominates clock edges even with an invalid code present
    bcd_in = 4'd13;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_held", {invalid_out, seven_seg_out}, reset_val());

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) step(i, "sweep_bcd");
    for (int i = 10; i < 16; i++) step(i, "sweep_hi");

    // Latency: new code applied just after an edge must not appear until the next edge
    step(3, "lat_3");
    bcd_in = 4'd8;
    @(negedge clk);
    check_eq("lat_hold", {invalid_out, seven_seg_out}, model(3));
    @(posedge clk);
    #1;
    check_eq("lat_8", {invalid_out, seven_seg_out}, model(8));

    // Asynchronous reset between edges
    #2;
    rst    = 1'b1;
    bcd_in = 4'd2;
    #1;
    check_eq("async_rst", {invalid_out, seven_seg_out}, reset_val());
    @(negedge clk);
    check_eq("async_rst_hold", {invalid_out, seven_seg_out}, reset_val());
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_release", {invalid_out, seven_seg_out}, model(2));

    for (int i = 0; i < 300; i++) begin
      int code;
      code = int'($urandom_range(0, 15));
      step(code, "random");
    end

    // Random mid-cycle resets interleaved with traffic
    for (int i = 0; i < 20; i++) begin
      int code;
      code = int'($urandom_range(0, 15));
      step(code, "rand_pre_rst");
      #(1 + $urandom_range(0, 2));
      rst = 1'b1;
      #1;
      check_eq("rand_async_rst", {invalid_out, seven_seg_out}, reset_val());
      @(negedge clk);
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
